// File: rtl/pipe_hazard_ctl.sv
// ============================================================================
// Module   : pipe_hazard_ctl
// Brief    : Load-use / HI-LO hazard and branch-redirect sequencing for the
//            IF/ID and ID/EX stages, with mult/div occupancy and stall counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic             ID_use_hilo,
    input  logic             ID_md,
    input  logic             EX_memread,
    input  logic [4:0]       EX_rt,
    input  logic             EX_md_start,
    input  logic             EX_branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;
    localparam logic [7:0] MD_RELOAD  = 8'(MD_LATENCY - 1);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [7:0] md_cnt;
    logic [7:0] md_cnt_nxt;
    logic       lu_haz;
    logic       md_haz;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            md_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Next-state logic; a start while busy reloads the window
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            ST_RUN: begin
                if (EX_md_start) begin
                    state_nxt  = ST_MD_BUSY;
                    md_cnt_nxt = MD_RELOAD;
                end
            end
            ST_MD_BUSY: begin
                if (EX_md_start) begin
                    md_cnt_nxt = MD_RELOAD;
                end else if (md_cnt == 8'd1) begin
                    state_nxt  = ST_RUN;
                    md_cnt_nxt = 8'd0;
                end else begin
                    md_cnt_nxt = md_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt  = ST_RUN;
                md_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Output logic: branch squash outranks any hazard in ID
    always_comb begin
        md_busy     = (state == ST_MD_BUSY);
        lu_haz      = EX_memread && (EX_rt != 5'd0) &&
                      ((ID_use_rs && (ID_rs == EX_rt)) ||
                       (ID_use_rt && (ID_rt == EX_rt)));
        md_haz      = md_busy && (ID_use_hilo || ID_md);
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (EX_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu_haz || md_haz) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_we && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctl
// Brief    : Directed scoreboard bench for pipe_hazard_ctl (32-bit and 4-bit counters).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic        ID_use_rs, ID_use_rt, ID_use_hilo, ID_md;
    logic        EX_memread, EX_md_start, EX_branch_taken;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, md_busy;
    logic [31:0] stall_cnt;
    logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_md_busy;
    logic [3:0]  sat_cnt;

    typedef struct {
        string       tag;
        logic        pc;
        logic        ifwe;
        logic        fl;
        logic        bub;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 0;

    pipe_hazard_ctl #(.MD_LATENCY(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_use_hilo(ID_use_hilo),
        .ID_md(ID_md), .EX_memread(EX_memread), .EX_rt(EX_rt),
        .EX_md_start(EX_md_start), .EX_branch_taken(EX_branch_taken),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctl #(.MD_LATENCY(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_use_hilo(ID_use_hilo),
        .ID_md(ID_md), .EX_memread(EX_memread), .EX_rt(EX_rt),
        .EX_md_start(EX_md_start), .EX_branch_taken(EX_branch_taken),
        .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .md_busy(s_md_busy), .stall_cnt(sat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed %0d expected %0d", tag, fld, obs, expv);
        end
    endtask

    // Push the expectation, then pop it against the outputs as they stand now.
    task automatic check_now(input string tag, input logic pc, input logic ifwe,
                             input logic fl, input logic bub, input logic busy);
        exp_t e;
        e.tag = tag; e.pc = pc; e.ifwe = ifwe; e.fl = fl;
        e.bub = bub; e.busy = busy; e.cnt = exp_cnt;
        sb.push_back(e);
        e = sb.pop_front();
        chk(e.tag, "pc_we",       32'(pc_we),       32'(e.pc));
        chk(e.tag, "ifid_we",     32'(ifid_we),     32'(e.ifwe));
        chk(e.tag, "ifid_flush",  32'(ifid_flush),  32'(e.fl));
        chk(e.tag, "idex_bubble", 32'(idex_bubble), 32'(e.bub));
        chk(e.tag, "md_busy",     32'(md_busy),     32'(e.busy));
        chk(e.tag, "stall_cnt",   stall_cnt,        e.cnt);
    endtask

    // One cycle: sample at negedge, advance past the posedge, track the counter.
    task automatic cyc(input string tag, input logic pc, input logic ifwe,
                       input logic fl, input logic bub, input logic busy);
        @(negedge clk);
        check_now(tag, pc, ifwe, fl, bub, busy);
        @(posedge clk);
        #1;
        if (!pc) exp_cnt = exp_cnt + 1;
    endtask

    task automatic idle_inputs();
        ID_rs = 0; ID_rt = 0; ID_use_rs = 0; ID_use_rt = 0; ID_use_hilo = 0;
        ID_md = 0; EX_memread = 0; EX_rt = 0; EX_md_start = 0; EX_branch_taken = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #2;
        check_now("reset", 1, 1, 0, 0, 0);
        #7 rst_n = 1'b1;
        cyc("idle", 1, 1, 0, 0, 0);

        // Load-use on rs: single stall cycle
        EX_memread = 1; EX_rt = 5; ID_rs = 5; ID_use_rs = 1;
        cyc("lu_rs", 0, 0, 0, 1, 0);
        EX_memread = 0;
        cyc("lu_rs_after", 1, 1, 0, 0, 0);

        // r0 destination and unused rt never stall
        EX_memread = 1; EX_rt = 0; ID_rs = 0; ID_use_rs = 1;
        cyc("lu_r0", 1, 1, 0, 0, 0);
        EX_rt = 5; ID_use_rs = 0; ID_rs = 0; ID_rt = 5; ID_use_rt = 0;
        cyc("lu_rt_unused", 1, 1, 0, 0, 0);
        ID_use_rt = 1;
        cyc("lu_rt", 0, 0, 0, 1, 0);
        EX_memread = 0;
        cyc("lu_rt_after", 1, 1, 0, 0, 0);

        // Branch outranks a load-use hazard
        EX_memread = 1; EX_rt = 5; ID_rs = 5; ID_use_rs = 1; EX_branch_taken = 1;
        cyc("branch_lu", 1, 1, 1, 1, 0);
        idle_inputs();
        cyc("branch_after", 1, 1, 0, 0, 0);

        // Fresh counter for the mult/div window
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        exp_cnt = 0;
        @(posedge clk);
        #1;
        EX_md_start = 1; ID_md = 1;
        cyc("md_start", 1, 1, 0, 0, 0);
        EX_md_start = 0;
        cyc("md_haz_md", 0, 0, 0, 1, 1);
        ID_md = 0; ID_use_hilo = 1;
        for (int i = 1; i < 31; i++) cyc("md_haz_hilo", 0, 0, 0, 1, 1);
        cyc("mfhi_issue", 1, 1, 0, 0, 0);
        ID_use_hilo = 0;

        // Asynchronous reset with md_cnt at 10
        EX_md_start = 1;
        cyc("md_start2", 1, 1, 0, 0, 0);
        EX_md_start = 0; ID_use_hilo = 1;
        for (int i = 0; i < 21; i++) cyc("md_pre_rst", 0, 0, 0, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_now("async_rst", 1, 1, 0, 0, 0);
        #1 rst_n = 1'b1;
        ID_use_hilo = 0;
        @(posedge clk);
        #1;
        EX_md_start = 1;
        cyc("md_start3", 1, 1, 0, 0, 0);
        EX_md_start = 0;
        for (int i = 0; i < 31; i++) cyc("md_window", 1, 1, 0, 0, 1);
        cyc("md_window_end", 1, 1, 0, 0, 0);

        // 4-bit counter saturation under continuous md_haz
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        exp_cnt = 0;
        @(posedge clk);
        #1;
        EX_md_start = 1;
        cyc("sat_start", 1, 1, 0, 0, 0);
        EX_md_start = 0; ID_use_hilo = 1;
        for (int i = 1; i <= 20; i++) begin
            cyc("sat_stall", 0, 0, 0, 1, 1);
            chk("sat_cnt", "stall_cnt4", 32'(sat_cnt), (i > 15) ? 32'd15 : 32'(i));
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
Pipeline sequencing controller for the ID/EX pipeline register and the stages around it. It detects load-use and multiply/divide (HI/LO) hazards and taken-branch redirects. It then drives the PC write enable, the IF/ID enable/flush and the ID/EX bubble select, which forces the ID_ctlwb/ID_ctlm/ID_ctlex fields to zero at the ID/EX input. It also tracks the multi-cycle mult/div unit occupancy and counts stall cycles for performance monitoring.

Parameters:
MD_LATENCY, 32, cycles the mult/div unit is busy after a start; legal range 2..255
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst_n  in  1  reset, asynchronous, active-low
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
ID_use_rs  in  1  ID instruction reads rs
ID_use_rt  in  1  ID instruction reads rt
ID_use_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo)
ID_md  in  1  ID instruction is mult/multu/div/divu
EX_memread  in  1  memory-read bit of EX_ctlm (load in EX)
EX_rt  in  5  destination rt of the instruction in EX
EX_md_start  in  1  mult/div instruction in EX; unit starts this cycle
EX_branch_taken  in  1  branch/jump in EX resolved taken
pc_we  out  1  PC register write enable
ifid_we  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID loads a NOP on next edge
idex_bubble  out  1  ID/EX control fields captured as zero on next edge
md_busy  out  1  mult/div unit occupied
stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0

Behaviour:
- Hazard terms are combinational from the current inputs and the registered state. Outputs respond in the same cycle and take effect at the next posedge.
- lu_haz = EX_memread & (EX_rt!=0) & ((ID_use_rs & ID_rs==EX_rt) | (ID_use_rt & ID_rt==EX_rt)).
- md_haz = md_busy & (ID_use_hilo | ID_md).
- Priority 1, EX_branch_taken=1: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1. Hazards are ignored that cycle, since the ID instruction is being squashed.
- Priority 2, lu_haz or md_haz (no branch): pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1.
- Otherwise: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- Load-use stall lasts exactly 1 cycle. The bubble clears EX_memread, so lu_haz drops on its own.
- FSM, two states, with an 8-bit down-counter md_cnt:
  - RUN: md_busy=0. EX_md_start -> MD_BUSY, md_cnt=MD_LATENCY-1.
  - MD_BUSY: md_busy=1. md_cnt decrements each cycle. When md_cnt==1 and the counter decrements, -> RUN.
  - EX_md_start in MD_BUSY (defensive only; prevented by md_haz): reload md_cnt=MD_LATENCY-1 and stay in MD_BUSY.
- EX_md_start and EX_branch_taken are mutually exclusive by construction. If both are asserted, both take effect.
- md_busy is high for exactly MD_LATENCY-1 cycles, starting the cycle after EX_md_start. A stalled mfhi in ID issues in the first cycle md_busy=0.
- stall_cnt increments at posedge when pc_we=0 and holds at all-ones (no wrap).
- Reset (rst_n low, any time, including mid-MD_BUSY) forces:
  - state=RUN, md_cnt=0, md_busy=0, stall_cnt=0.
  - Combinational outputs evaluate with md_busy=0.

Test Plan:
- lw r5 in EX (EX_memread=1, EX_rt=5), ID add reads rs=5 -> exactly one cycle with pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt goes 0->1.
- lw r0 in EX, ID reads rs=0; then lw r5 in EX with ID_use_rt=0, ID_rt=5 -> no stall in either case, pc_we=1 throughout.
- EX_md_start pulse (MD_LATENCY=32), mfhi held in ID -> md_busy=1 for 31 cycles, stall for 31 cycles; stall_cnt=31; mfhi issues on cycle 32.
- EX_branch_taken=1 in the same cycle as lu_haz -> pc_we=1, ifid_flush=1, idex_bubble=1, ifid_we=1; stall_cnt unchanged.
- rst_n pulsed low asynchronously at md_cnt=10 -> md_busy=0 and stall_cnt=0 immediately, with no clock edge; after release a new EX_md_start gives a full 31-cycle busy window.
- CNT_W=4, continuous md_haz for 20 cycles -> stall_cnt saturates at 15 and holds.
